// File: rtl/enet_rx_frame.sv
// Receive MAC framer: strips preamble/SFD/FCS from a byte-wide rx stream, forwards payload
// as a valid/last stream and reports per-frame status plus good/bad frame counters.
module enet_rx_frame #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_err,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic        crc_err,
  output logic        len_err,
  output logic        phy_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

  state_e          state_q, state_d;
  logic            rx_dv_q;
  logic [31:0]     crc_q, crc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [4:0][7:0] sr_q, sr_d;
  logic            pend_q, pend_d;

  logic [7:0]  m_data_d;
  logic        m_valid_d, m_last_d, m_err_d, frame_done_d;
  logic [15:0] frame_len_d, good_cnt_d, bad_cnt_d;
  logic        crc_err_d, len_err_d, phy_err_d;

  logic crc_bad, len_bad, any_err;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_bad = (crc_q != CrcResidue);
  assign len_bad = ({16'h0, cnt_q} < MIN_LEN) || ({16'h0, cnt_q} > MAX_LEN);
  assign any_err = crc_bad | len_bad | pend_q;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    pend_d       = pend_q;
    m_data_d     = m_data;
    m_valid_d    = 1'b0;
    m_last_d     = 1'b0;
    m_err_d      = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len;
    crc_err_d    = crc_err;
    len_err_d    = len_err;
    phy_err_d    = phy_err;
    good_cnt_d   = good_cnt;
    bad_cnt_d    = bad_cnt;

    unique case (state_q)
      StIdle: begin
        if (rx_dv && !rx_dv_q) begin
          state_d = (rxd == 8'h55) ? StPreamble : StDrop;
        end
      end
      StPreamble: begin
        if (!rx_dv) begin
          state_d = StIdle;
        end else if (rxd == 8'hD5) begin
          state_d = StData;
          crc_d   = '1;
          cnt_d   = '0;
          sr_d    = '0;
          pend_d  = 1'b0;
        end else if (rxd != 8'h55) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (!rx_dv) state_d = StIdle;
      end
      StData: begin
        if (rx_dv) begin
          sr_d  = {sr_q[3:0], rxd};
          crc_d = crc_next(crc_q, rxd);
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (rx_er) pend_d = 1'b1;
          // Five-byte delay keeps the trailing FCS out of the payload stream.
          if (cnt_q >= 16'd5) begin
            m_data_d  = sr_q[4];
            m_valid_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
          if (cnt_q >= 16'd5) begin
            m_data_d  = sr_q[4];
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_err_d   = any_err;
          end
          frame_done_d = 1'b1;
          frame_len_d  = cnt_q;
          crc_err_d    = crc_bad;
          len_err_d    = len_bad;
          phy_err_d    = pend_q;
          if (any_err) bad_cnt_d = bad_cnt + 16'd1;
          else         good_cnt_d = good_cnt + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      // Treat rx_dv as already high so a frame in flight at release is not picked up mid-way.
      rx_dv_q    <= 1'b1;
      crc_q      <= '1;
      cnt_q      <= '0;
      sr_q       <= '0;
      pend_q     <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_err      <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      phy_err    <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      rx_dv_q    <= rx_dv;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      pend_q     <= pend_d;
      m_data     <= m_data_d;
      m_valid    <= m_valid_d;
      m_last     <= m_last_d;
      m_err      <= m_err_d;
      frame_done <= frame_done_d;
      frame_len  <= frame_len_d;
      crc_err    <= crc_err_d;
      len_err    <= len_err_d;
      phy_err    <= phy_err_d;
      good_cnt   <= good_cnt_d;
      bad_cnt    <= bad_cnt_d;
    end
  end

endmodule

// File: tb/tb_enet_rx_frame.sv
// Bench for enet_rx_frame: a frame-level model predicts payload beats and per-frame status,
// a per-cycle monitor checks the DUT against it, and directed frames pin key literals.
module tb_enet_rx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        rx_dv, rx_er;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_err, frame_done;
  logic [15:0] frame_len, good_cnt, bad_cnt;
  logic        crc_err, len_err, phy_err;

  enet_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
    .frame_done(frame_done), .frame_len(frame_len), .crc_err(crc_err),
    .len_err(len_err), .phy_err(phy_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       err;
  } beat_t;
  typedef struct {
    logic [15:0] len;
    logic        crc;
    logic        lenerr;
    logic        phy;
    logic [15:0] good;
    logic [15:0] bad;
  } stat_t;

  beat_t      beat_q[$];
  stat_t      stat_q[$];
  logic [7:0] pre_q[$];
  logic [7:0] dat_q[$];

  int tests = 0, fails = 0;
  int mgood = 0, mbad = 0;
  int nbeats = 0, ndone = 0;
  int first_cyc = 0;
  bit lat_armed = 0;
  bit prev_open = 0;
  stat_t last_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Standard Ethernet CRC-32 over the first n bytes of dat_q, final value (inverted).
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, dat_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int npay, input logic [7:0] base);
    logic [31:0] fcs;
    dat_q.delete();
    for (int i = 0; i < npay; i++) dat_q.push_back(8'(base + 8'(i)));
    fcs = crc32(npay);
    for (int i = 0; i < 4; i++) dat_q.push_back(fcs[8*i +: 8]);
  endtask

  task automatic std_pre();
    pre_q.delete();
    for (int i = 0; i < 7; i++) pre_q.push_back(8'h55);
    pre_q.push_back(8'hD5);
  endtask

  // Frame-level prediction: payload = everything except the last 4 bytes.
  task automatic model_push(input int er_idx);
    int    n;
    stat_t st;
    bit    crc_ok, any;
    n = dat_q.size();
    crc_ok = (n >= 4) && (crc32(n - 4) == {dat_q[n-1], dat_q[n-2], dat_q[n-3], dat_q[n-4]});
    st.len    = 16'(n);
    st.crc    = !crc_ok;
    st.lenerr = (n < 64) || (n > 1518);
    st.phy    = (er_idx >= 0) && (er_idx < n);
    any = st.crc || st.lenerr || st.phy;
    if (any) mbad++; else mgood++;
    st.good = 16'(mgood);
    st.bad  = 16'(mbad);
    for (int i = 0; i + 4 < n; i++) begin
      beat_q.push_back('{d: dat_q[i], last: (i == n - 5), err: (i == n - 5) && any});
    end
    stat_q.push_back(st);
  endtask

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(posedge clk);
    #1;
    rxd = b; rx_dv = dv; rx_er = er;
  endtask

  task automatic send(input int er_idx, input bit chk_lat, input int gap);
    foreach (pre_q[i]) drive(pre_q[i], 1'b1, 1'b0);
    for (int i = 0; i < dat_q.size(); i++) begin
      drive(dat_q[i], 1'b1, 1'(i == er_idx));
      if (i == 0 && chk_lat) begin
        first_cyc = cyc;
        lat_armed = 1;
      end
    end
    for (int g = 0; g < gap; g++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic drained(input string name);
    int k;
    k = 0;
    while ((beat_q.size() + stat_q.size()) != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(beat_q.size() + stat_q.size()), 64'd0);
  endtask

  // Per-cycle monitor against the model's queues.
  always @(negedge clk) begin
    beat_t b;
    stat_t s;
    if (m_valid) begin
      nbeats++;
      if (lat_armed) begin
        check("first_beat_latency", 64'(cyc), 64'(first_cyc + 6));
        lat_armed = 0;
      end
      if (beat_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data %0h last %0b, none expected", m_data, m_last);
      end else begin
        b = beat_q.pop_front();
        check("beat", {54'h0, m_data, m_last, m_err}, {54'h0, b.d, b.last, b.err});
      end
    end
    if (prev_open) check("beat_contiguous", 64'(m_valid), 64'd1);
    prev_open = !rst && m_valid && !m_last;
    if (frame_done) begin
      ndone++;
      if (stat_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame_done: got len %0d, none expected", frame_len);
      end else begin
        s = stat_q.pop_front();
        last_st = s;
        check("status", {13'h0, frame_len, crc_err, len_err, phy_err, good_cnt, bad_cnt},
              {13'h0, s.len, s.crc, s.lenerr, s.phy, s.good, s.bad});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb0, nd0;
    rst = 1'b1; rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {m_data, m_valid, m_last, m_err, frame_done, frame_len, crc_err,
          len_err, phy_err, good_cnt, bad_cnt}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model's CRC on the standard check string.
    dat_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_pin", 64'(crc32(9)), 64'hCBF43926);

    // Good 64-byte frame.
    std_pre(); build(60, 8'h00); model_push(-1);
    nb0 = nbeats;
    send(-1, 1'b1, 1); drained("f1_drained");
    check("f1_beats", 64'(nbeats - nb0), 64'd60);
    check("f1_len", 64'(last_st.len), 64'd64);
    check("f1_good_cnt", 64'(good_cnt), 64'd1);
    check("f1_err_flags", {61'h0, crc_err, len_err, phy_err}, 64'd0);

    // Same frame, one FCS bit flipped.
    std_pre(); build(60, 8'h00); dat_q[62] = dat_q[62] ^ 8'h10; model_push(-1);
    send(-1, 1'b1, 1); drained("f2_drained");
    check("f2_crc_err", 64'(crc_err), 64'd1);
    check("f2_bad_cnt", 64'(bad_cnt), 64'd1);

    // 40-byte runt with good CRC.
    std_pre(); build(36, 8'h40); model_push(-1);
    nb0 = nbeats;
    send(-1, 1'b1, 1); drained("f3_drained");
    check("f3_beats", 64'(nbeats - nb0), 64'd36);
    check("f3_flags", {62'h0, len_err, crc_err}, 64'b10);

    // 1519-byte oversize frame.
    std_pre(); build(1515, 8'h07); model_push(-1);
    send(-1, 1'b1, 1); drained("f4_drained");
    check("f4_len", 64'(frame_len), 64'd1519);
    check("f4_len_err", 64'(len_err), 64'd1);

    // rx_er on the 10th data byte of a valid frame.
    std_pre(); build(60, 8'hA0); model_push(9);
    nb0 = nbeats;
    send(9, 1'b1, 1); drained("f5_drained");
    check("f5_beats", 64'(nbeats - nb0), 64'd60);
    check("f5_phy_err", 64'(phy_err), 64'd1);

    // Bad preamble byte: frame dropped silently.
    pre_q = '{8'h55, 8'h55, 8'h5D}; build(12, 8'h11);
    nb0 = nbeats; nd0 = ndone;
    send(-1, 1'b0, 1);
    repeat (3) @(negedge clk);
    check("f6_no_beats", 64'(nbeats - nb0), 64'd0);
    check("f6_no_done", 64'(ndone - nd0), 64'd0);

    // Valid frame after one idle cycle, then a 3-byte runt back-to-back, then another frame.
    std_pre(); build(60, 8'h20); model_push(-1);
    send(-1, 1'b1, 1);
    std_pre(); dat_q = '{8'h01, 8'h02, 8'h03}; model_push(-1);
    nb0 = nbeats;
    send(-1, 1'b0, 1);
    std_pre(); build(70, 8'h33); model_push(-1);
    send(-1, 1'b1, 1); drained("f7_drained");
    check("f7_good_cnt", 64'(good_cnt), 64'd3);
    check("f7_bad_cnt", 64'(bad_cnt), 64'd5);

    // Reset mid-payload with rx_dv held high.
    std_pre(); build(60, 8'h90);
    for (int i = 0; i < 15; i++) beat_q.push_back('{d: dat_q[i], last: 1'b0, err: 1'b0});
    nd0 = ndone;
    foreach (pre_q[i]) drive(pre_q[i], 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(dat_q[i], 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; rxd = dat_q[20];
    @(posedge clk);
    #1 rst = 1'b0; rxd = dat_q[21];
    mgood = 0; mbad = 0;
    @(negedge clk);
    check("rst_mid_outputs", {m_valid, m_last, frame_done, frame_len, good_cnt, bad_cnt}, 64'd0);
    for (int i = 22; i < dat_q.size(); i++) drive(dat_q[i], 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drained("rst_drained");
    check("rst_no_done", 64'(ndone - nd0), 64'd0);

    std_pre(); build(60, 8'h55); model_push(-1);
    send(-1, 1'b1, 1); drained("f8_drained");
    check("f8_good_cnt", 64'(good_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enet_rx_frame.md
Name: enet_rx_frame

Overview:
- Receive-side MAC framer directly downstream of the Ethernet interface/clock selector.
- Consumes the selected byte-wide receive stream (rxd/rx_dv/rx_er) in the rx clock domain.
- Strips preamble, SFD and FCS, and forwards payload bytes as a valid/last stream.
- Produces per-frame status (length, CRC, length, PHY error) and wrapping statistics counters.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive
MAX_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive

Ports:
clk  input  1  receive clock (selected rx clock)
rst  input  1  reset; the block has one clock, and reset is synchronous and active-high
rxd  input  8  receive byte
rx_dv  input  1  receive data valid
rx_er  input  1  receive error
m_data  output  8  payload byte
m_valid  output  1  m_data valid; single-cycle beat, no backpressure
m_last  output  1  marks the last payload byte of the frame
m_err  output  1  asserted with m_last when crc_err|len_err|phy_err
frame_done  output  1  one-cycle pulse at end of each frame that reached DATA
frame_len  output  16  bytes after SFD including FCS, saturating at 0xFFFF
crc_err  output  1  FCS residue mismatch; held until next frame_done
len_err  output  1  frame_len < MIN_LEN or > MAX_LEN; held until next frame_done
phy_err  output  1  rx_er seen during DATA; held until next frame_done
good_cnt  output  16  count of frames with no error, wraps
bad_cnt  output  16  count of frames with any error, wraps

Behaviour:
- Reset: all outputs 0; state IDLE; registered rx_dv_q set to 1, so a frame already in progress at reset release is ignored.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rising rx_dv (rx_dv=1, rx_dv_q=0) with rxd=0x55 -> PREAMBLE.
  - rising rx_dv with any other rxd -> DROP.
- PREAMBLE:
  - rxd=0x55: stay; any number of 0x55 bytes is accepted.
  - rxd=0xD5 -> DATA; clear CRC to 0xFFFFFFFF, byte count, 5-byte shift buffer and error flags.
  - any other rxd -> DROP.
  - rx_dv=0 -> IDLE; no status.
- DROP: wait for rx_dv=0 -> IDLE; no m_valid, no frame_done.
- DATA with rx_dv=1:
  - rxd shifts into buffer sr[0..4].
  - CRC updated (reflected CRC-32, polynomial 0xEDB88320, LSB first).
  - byte count increments, saturating.
  - rx_er=1 sets phy_err_pending.
  - If count (before increment) >= 5: m_data<=sr[4], m_valid<=1, m_last<=0.
- DATA with rx_dv=0 (end cycle): -> IDLE, and on that same edge:
  - if count >= 5: emit sr[4] with m_valid=1, m_last=1, m_err.
  - frame_done=1; frame_len=count.
  - crc_err = (CRC register != 0xDEBB20E3).
  - len_err per MIN_LEN/MAX_LEN; phy_err = pending flag.
  - good_cnt or bad_cnt increments.
  - The 4 remaining buffer bytes (FCS) are discarded.
- Latency: payload byte on rxd in cycle c appears on m_data in cycle c+6; beats are contiguous with no gaps, including the m_last beat.
- Frames with count <= 4: no m_valid beats; frame_done still pulses; len_err=1.
- rx_er outside DATA: ignored.
- Back-to-back frames: IDLE may accept a new rising rx_dv in the cycle immediately after the end cycle.
- Synchronous reset mid-frame: buffer and FSM cleared immediately; no m_last and no frame_done for that frame; the block waits for rx_dv low before re-arming.
- m_valid, m_last, m_err, frame_done are single-cycle registered pulses. frame_len, crc_err, len_err, phy_err hold their value until the next frame_done.

Test Plan:
- 7×0x55, 0xD5, 60 bytes 0x00..0x3B plus correct FCS -> 60 beats 0x00..0x3B; m_last on 0x3B; frame_len=64; all error flags 0; good_cnt=1; first beat 6 cycles after byte 0x00.
- Same frame with one FCS bit flipped -> identical beats; m_err=1 on last; crc_err=1; bad_cnt=1.
- 40-byte frame (36 payload + FCS) with valid CRC -> 36 beats; len_err=1, crc_err=0. Separately, 1519-byte frame -> len_err=1.
- rx_er pulsed on 10th data byte of valid 64-byte frame -> phy_err=1, m_err=1; all 60 beats still forwarded.
- Preamble 0x55,0x55,0x5D then data until rx_dv low -> DROP; no m_valid, no frame_done. Next valid frame one idle cycle later is received correctly.
- rst asserted mid-payload with rx_dv held high -> outputs 0 next cycle; no frame_done. Remainder of that frame ignored; following frame received normally.
